portal_msg_assembler: RTL and testbench

- Receive-side portal block that turns a stream of 32-bit host words into whole method messages on a pipe.
- It is the inverse of the indication-output serializer, which packs a call into a 96-bit pipe message.
- Accepts one word per cycle, checks the header, and gathers MSG_WORDS words into a one-entry holding register.
- Drives the downstream pipe$enq method (96-bit) with the RDY/ENA method handshake and keeps status counters.

---
 rtl/portal_msg_assembler.sv | 129 ++++++++++++
 tb/tb_portal_msg_assembler.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/portal_msg_assembler.sv
// Receive-side portal message assembler.
// Gathers MSG_WORDS host words (header first) into a one-entry holding register
// and delivers the whole message on the pipe_enq method with RDY/ENA handshaking.
// Headers whose length field differs from MSG_WORDS are dropped and counted.
// Assumes MSG_WORDS >= 2: a header is always followed by at least one body word.
module portal_msg_assembler #(
  parameter int unsigned MSG_WORDS = 3,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic                    word__ENA,
  input  logic [31:0]             word_v,
  output logic                    word__RDY,
  output logic                    pipe_enq__ENA,
  output logic [MSG_WORDS*32-1:0] pipe_enq_v,
  input  logic                    pipe_enq__RDY,
  output logic [CNT_WIDTH-1:0]    msg_count,
  output logic [CNT_WIDTH-1:0]    drop_count,
  output logic                    err_bad_len
);

  localparam int unsigned BeatW = (MSG_WORDS > 2) ? $clog2(MSG_WORDS) : 1;
  localparam int unsigned MsgW  = MSG_WORDS * 32;
  localparam logic [BeatW-1:0] LastBeat = BeatW'(MSG_WORDS - 1);

  typedef enum logic [0:0] {StHdr, StBody} state_e;

  state_e                 state_q, state_d;
  logic [BeatW-1:0]       beat_q, beat_d;
  logic                   full_q, full_d;
  logic [MsgW-1:0]        hold_q, hold_d;
  logic [CNT_WIDTH-1:0]   msg_count_q, msg_count_d;
  logic [CNT_WIDTH-1:0]   drop_count_q, drop_count_d;
  logic                   err_q, err_d;

  logic accept;
  logic hdr_ok;
  logic slot_we;
  logic deliver;

  // A word is only taken while the holding register is empty; ENA while full is ignored.
  assign accept  = word__ENA & ~full_q;
  assign hdr_ok  = (word_v[31:16] == 16'(MSG_WORDS));
  assign slot_we = accept & ((state_q == StBody) | hdr_ok);
  assign deliver = full_q & pipe_enq__RDY;

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= StHdr;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: valid header opens a message, last body word closes it.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StHdr:   if (accept && hdr_ok) state_d = StBody;
      StBody:  if (accept && beat_q == LastBeat) state_d = StHdr;
      default: state_d = StHdr;
    endcase
  end

  // Output logic: RDY comes straight from the full flag, so no path from pipe_enq__RDY.
  always_comb begin
    word__RDY     = ~full_q;
    pipe_enq__ENA = deliver;
    pipe_enq_v    = hold_q;
    msg_count     = msg_count_q;
    drop_count    = drop_count_q;
    err_bad_len   = err_q;
  end

  // Datapath next-state: slot writes, beat counter, full flag and status counters.
  always_comb begin
    beat_d       = beat_q;
    full_d       = full_q;
    hold_d       = hold_q;
    msg_count_d  = msg_count_q;
    drop_count_d = drop_count_q;
    err_d        = err_q;

    if (slot_we) begin
      for (int unsigned i = 0; i < MSG_WORDS; i++) begin
        if (beat_q == BeatW'(i)) hold_d[i*32 +: 32] = word_v;
      end
      if (state_q == StBody && beat_q == LastBeat) begin
        beat_d = '0;
        full_d = 1'b1;
      end else begin
        beat_d = beat_q + BeatW'(1);
      end
    end

    if (accept && state_q == StHdr && !hdr_ok) begin
      err_d = 1'b1;
      if (drop_count_q != '1) drop_count_d = drop_count_q + CNT_WIDTH'(1);
    end

    // accept and deliver are mutually exclusive (both depend on full_q of opposite sense).
    if (deliver) begin
      full_d      = 1'b0;
      msg_count_d = msg_count_q + CNT_WIDTH'(1);
    end
  end

  // Datapath registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      beat_q       <= '0;
      full_q       <= 1'b0;
      hold_q       <= '0;
      msg_count_q  <= '0;
      drop_count_q <= '0;
      err_q        <= 1'b0;
    end else begin
      beat_q       <= beat_d;
      full_q       <= full_d;
      hold_q       <= hold_d;
      msg_count_q  <= msg_count_d;
      drop_count_q <= drop_count_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_portal_msg_assembler.sv
// Bench for portal_msg_assembler: scoreboard of expected pipe messages, popped on each ENA.
// Counters use a narrow width so wrap and saturation are reached quickly.
module tb_portal_msg_assembler;

  localparam int unsigned MW = 3;
  localparam int unsigned CW = 8;

  logic             CLK;
  logic             nRST;
  logic             word__ENA;
  logic [31:0]      word_v;
  logic             word__RDY;
  logic             pipe_enq__ENA;
  logic [MW*32-1:0] pipe_enq_v;
  logic             pipe_enq__RDY;
  logic [CW-1:0]    msg_count;
  logic [CW-1:0]    drop_count;
  logic             err_bad_len;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned ena_pulses = 0;
  logic [MW*32-1:0] sb[$];

  portal_msg_assembler #(
    .MSG_WORDS(MW),
    .CNT_WIDTH(CW)
  ) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .word__ENA    (word__ENA),
    .word_v       (word_v),
    .word__RDY    (word__RDY),
    .pipe_enq__ENA(pipe_enq__ENA),
    .pipe_enq_v   (pipe_enq_v),
    .pipe_enq__RDY(pipe_enq__RDY),
    .msg_count    (msg_count),
    .drop_count   (drop_count),
    .err_bad_len  (err_bad_len)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Monitor: every delivered message must match the oldest expected one.
  always @(negedge CLK) begin
    if (nRST && pipe_enq__ENA) begin
      ena_pulses++;
      if (sb.size() == 0) begin
        check("unexpected_msg", 128'(pipe_enq_v), 128'(0));
      end else begin
        check("msg", 128'(pipe_enq_v), 128'(sb.pop_front()));
      end
    end
  end

  task automatic cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    word__ENA = 1'b0;
    word_v = '0;
    repeat (2) cycle();
    sb.delete();
    #3 nRST = 1'b1;
    cycle();
  endtask

  task automatic send_word(input logic [31:0] w);
    int n = 0;
    while (!word__RDY && n < 100) begin
      cycle();
      n++;
    end
    if (!word__RDY) check("rdy_timeout", 128'(word__RDY), 128'(1));
    word__ENA = 1'b1;
    word_v = w;
    cycle();
    word__ENA = 1'b0;
  endtask

  task automatic send_msg(input logic [31:0] hdr, input logic [31:0] w1, input logic [31:0] w2);
    if (hdr[31:16] == 16'(MW)) sb.push_back({w2, w1, hdr});
    send_word(hdr);
    send_word(w1);
    send_word(w2);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      cycle();
      n++;
    end
    check("drain", 128'(sb.size()), 128'(0));
    cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned p0;
    logic [15:0] len;
    pipe_enq__RDY = 1'b1;

    // Reset then idle.
    do_reset();
    check("rst_rdy", 128'(word__RDY), 128'(1));
    check("rst_ena", 128'(pipe_enq__ENA), 128'(0));
    check("rst_v", 128'(pipe_enq_v), 128'(0));
    check("rst_msgcnt", 128'(msg_count), 128'(0));
    check("rst_err", 128'(err_bad_len), 128'(0));

    // Single message: ENA one cycle after last word, RDY low for exactly one cycle.
    send_msg(32'h0003_0001, 32'h0000_0005, 32'hDEAD_BEEF);
    check("single_rdy_low", 128'(word__RDY), 128'(0));
    check("single_ena", 128'(pipe_enq__ENA), 128'(1));
    check("single_v", 128'(pipe_enq_v), 128'(96'hDEADBEEF_00000005_00030001));
    cycle();
    check("single_rdy_back", 128'(word__RDY), 128'(1));
    check("single_ena_off", 128'(pipe_enq__ENA), 128'(0));
    check("single_msgcnt", 128'(msg_count), 128'(1));
    check("single_sb", 128'(sb.size()), 128'(0));

    // Backpressure, including an illegal ENA while RDY=0.
    do_reset();
    pipe_enq__RDY = 1'b0;
    send_msg(32'h0003_0002, 32'h1111_2222, 32'h3333_4444);
    p0 = ena_pulses;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        word__ENA = 1'b1;
        word_v = 32'h0003_0009;
      end
      check("bp_rdy", 128'(word__RDY), 128'(0));
      check("bp_v", 128'(pipe_enq_v), 128'(96'h33334444_11112222_00030002));
      cycle();
      word__ENA = 1'b0;
    end
    check("bp_msgcnt_hold", 128'(msg_count), 128'(0));
    pipe_enq__RDY = 1'b1;
    repeat (3) cycle();
    check("bp_one_pulse", 128'(ena_pulses - p0), 128'(1));
    check("bp_msgcnt", 128'(msg_count), 128'(1));
    send_msg(32'h0003_0003, 32'hAAAA_0001, 32'hBBBB_0002);
    wait_drain();
    check("bp_after_msgcnt", 128'(msg_count), 128'(2));

    // Bad header followed by a valid message.
    do_reset();
    send_word(32'h0005_0001);
    check("bad_drop", 128'(drop_count), 128'(1));
    check("bad_err", 128'(err_bad_len), 128'(1));
    send_msg(32'h0003_0004, 32'h0000_0005, 32'hCAFE_F00D);
    wait_drain();
    check("bad_msgcnt", 128'(msg_count), 128'(1));
    check("bad_drop_keep", 128'(drop_count), 128'(1));

    // Asynchronous reset mid-message.
    do_reset();
    send_word(32'h0001_0001);
    check("mid_pre_err", 128'(err_bad_len), 128'(1));
    send_word(32'h0003_0007);
    send_word(32'h0000_0077);
    #2 nRST = 1'b0;
    #1;
    check("mid_async_err", 128'(err_bad_len), 128'(0));
    check("mid_async_drop", 128'(drop_count), 128'(0));
    check("mid_async_rdy", 128'(word__RDY), 128'(1));
    #2 nRST = 1'b1;
    cycle();
    p0 = ena_pulses;
    send_msg(32'h0003_0008, 32'h8888_0001, 32'h8888_0002);
    wait_drain();
    check("mid_one_msg", 128'(ena_pulses - p0), 128'(1));
    check("mid_msgcnt", 128'(msg_count), 128'(1));

    // Message counter wraps.
    do_reset();
    for (int i = 0; i < (1 << CW) + 1; i++) begin
      send_msg({16'(MW), 16'(i)}, $urandom, $urandom);
    end
    wait_drain();
    check("wrap_msgcnt", 128'(msg_count), 128'(1));

    // Drop counter saturates; lengths 0 and 1 are drops too.
    do_reset();
    for (int i = 0; i < (1 << CW) - 1; i++) begin
      len = 16'(i % 8);
      if (len == 16'(MW)) len = 16'hFFFF;
      send_word({len, 16'(i)});
    end
    check("sat_reach", 128'(drop_count), 128'({CW{1'b1}}));
    send_word(32'h0000_0001);
    send_word(32'h0001_0002);
    check("sat_hold", 128'(drop_count), 128'({CW{1'b1}}));
    check("sat_err", 128'(err_bad_len), 128'(1));
    check("sat_no_msg", 128'(msg_count), 128'(0));

    repeat (2) cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
